// File: rtl/aes_job_arbiter.sv
// Shares one aes_core between two requesters: round-robin grant, one job in
// flight, held response until consumed, and a bounded wait for core_done.
module aes_job_arbiter #(
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned DW      = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_plaintext,
    input  logic [DW-1:0] req0_key,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_plaintext,
    input  logic [DW-1:0] req1_key,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_ciphertext,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_ciphertext,
    output logic          core_start,
    output logic [DW-1:0] core_plaintext,
    output logic [DW-1:0] core_key,
    input  logic [DW-1:0] core_ciphertext,
    input  logic          core_done,
    output logic          timeout_err
);

    localparam int unsigned   CW       = 16;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        state_q;
    logic          last_q;
    logic          owner_q;
    logic          rsp0_valid_q;
    logic          rsp1_valid_q;
    logic          core_start_q;
    logic          timeout_err_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] pt_q;
    logic [DW-1:0] key_q;
    logic [DW-1:0] result_q;

    logic grant1_c;
    logic accept_c;
    logic rsp_fire_c;

    // Requester 1 wins alone, or under contention when 0 was served last.
    always_comb begin
        grant1_c = req1_valid;
        if (req0_valid && req1_valid) begin
            grant1_c = ~last_q;
        end
    end

    assign req0_ready = ~reset & (state_q == S_IDLE) & req0_valid & ~grant1_c;
    assign req1_ready = ~reset & (state_q == S_IDLE) & req1_valid & grant1_c;
    assign accept_c   = req0_ready | req1_ready;
    assign rsp_fire_c = (rsp0_valid_q & rsp0_ready) | (rsp1_valid_q & rsp1_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_q        <= 1'b1;
            owner_q       <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            core_start_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
            pt_q          <= '0;
            key_q         <= '0;
            result_q      <= '0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        owner_q      <= grant1_c;
                        pt_q         <= grant1_c ? req1_plaintext : req0_plaintext;
                        key_q        <= grant1_c ? req1_key : req0_key;
                        core_start_q <= 1'b1;
                        state_q      <= S_START;
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    // Done wins over a timeout landing in the same cycle.
                    if (core_done) begin
                        result_q     <= core_ciphertext;
                        rsp0_valid_q <= ~owner_q;
                        rsp1_valid_q <= owner_q;
                        state_q      <= S_RESP;
                    end else if (cnt_q == LAST_CNT) begin
                        result_q      <= '0;
                        timeout_err_q <= 1'b1;
                        rsp0_valid_q  <= ~owner_q;
                        rsp1_valid_q  <= owner_q;
                        state_q       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_fire_c) begin
                        last_q       <= owner_q;
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp0_valid      = rsp0_valid_q;
    assign rsp1_valid      = rsp1_valid_q;
    assign rsp0_ciphertext = rsp0_valid_q ? result_q : '0;
    assign rsp1_ciphertext = rsp1_valid_q ? result_q : '0;
    assign core_start      = core_start_q;
    assign core_plaintext  = pt_q;
    assign core_key        = key_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Randomized bench for aes_job_arbiter: a transaction-timeline reference model
// predicts grants, start pulse, response timing/data and the sticky error.
module tb_aes_job_arbiter;

    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned DW      = 128;
    localparam logic [DW-1:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [DW-1:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_plaintext, req0_key, req1_plaintext, req1_key;
    logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [DW-1:0] rsp0_ciphertext, rsp1_ciphertext;
    logic          core_start, core_done;
    logic [DW-1:0] core_plaintext, core_key, core_ciphertext;
    logic          timeout_err;

    always #5 clk = ~clk;

    aes_job_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_plaintext(req0_plaintext), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_plaintext(req1_plaintext), .req1_key(req1_key),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_ciphertext(rsp0_ciphertext),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_ciphertext(rsp1_ciphertext),
        .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
        .core_ciphertext(core_ciphertext), .core_done(core_done), .timeout_err(timeout_err)
    );

    // Requester-side stimulus state
    logic          rv[2];
    logic [DW-1:0] rpt[2];
    logic [DW-1:0] rkey[2];
    logic          rrdy[2];
    logic          consumed[2];
    assign req0_valid = rv[0];  assign req0_plaintext = rpt[0];  assign req0_key = rkey[0];
    assign req1_valid = rv[1];  assign req1_plaintext = rpt[1];  assign req1_key = rkey[1];
    assign rsp0_ready = rrdy[0];
    assign rsp1_ready = rrdy[1];

    // Stimulus knobs (percentages / latency range)
    int p_req[2];
    int p_rdy, p_stray, p_never, lat_min, lat_max;
    bit kat_mode;

    // Bench-side core model
    int            c_sched;
    logic [DW-1:0] c_pt, c_key;

    // Reference model: one job timeline (accept cycle, response cycle)
    bit            m_busy, m_owner, m_last, m_err, m_known, m_kat, prev_rst;
    int            m_tacc, m_rcyc;
    logic [DW-1:0] m_ct, m_cur_pt, m_cur_key;

    int cyc;
    int n_kat;
    int unsigned n_vec, n_bad;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] pt, input logic [DW-1:0] key);
        if (pt == KAT_PT && key == KAT_KEY) return KAT_CT;
        return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
    endfunction

    task automatic drive_inputs();
        for (int r = 0; r < 2; r++) begin
            if (consumed[r] || reset) rv[r] = 1'b0;
            consumed[r] = 1'b0;
            if (!rv[r] && !reset && int'($urandom_range(99)) < p_req[r]) begin
                rv[r]   = 1'b1;
                rpt[r]  = (kat_mode && r == 0) ? KAT_PT  : rand128();
                rkey[r] = (kat_mode && r == 0) ? KAT_KEY : rand128();
            end
            rrdy[r] = int'($urandom_range(99)) < p_rdy;
        end
        if (cyc == c_sched) begin
            core_done       = 1'b1;
            core_ciphertext = core_fn(c_pt, c_key);
            c_sched         = -1;
        end else begin
            core_done       = (c_sched < 0) && int'($urandom_range(99)) < p_stray;
            core_ciphertext = rand128();
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 1; m_err = 0; m_known = 0; m_kat = 0;
        m_cur_pt = '0; m_cur_key = '0; m_ct = '0;
    endtask

    task automatic check_and_model();
        logic exp_r0, exp_r1, in_resp;
        bit   skip;
        skip   = reset && !prev_rst;
        exp_r0 = !reset && !m_busy && req0_valid && (!req1_valid || m_last);
        exp_r1 = !reset && !m_busy && req1_valid && (!req0_valid || !m_last);
        in_resp = m_busy && m_known && cyc >= m_rcyc;
        check_eq("req0_ready", DW'(req0_ready), DW'(exp_r0));
        check_eq("req1_ready", DW'(req1_ready), DW'(exp_r1));
        if (!skip) begin
            check_eq("core_start", DW'(core_start), DW'(m_busy && cyc == m_tacc + 1));
            check_eq("rsp0_valid", DW'(rsp0_valid), DW'(in_resp && !m_owner));
            check_eq("rsp1_valid", DW'(rsp1_valid), DW'(in_resp && m_owner));
            check_eq("timeout_err", DW'(timeout_err), DW'(m_err));
            if (in_resp)
                check_eq("rsp_ct", m_owner ? rsp1_ciphertext : rsp0_ciphertext, m_ct);
            if (m_busy)
                check_eq("nonowner_ct", m_owner ? rsp0_ciphertext : rsp1_ciphertext, '0);
            if (prev_rst) begin
                check_eq("rst_ct0", rsp0_ciphertext, '0);
                check_eq("rst_ct1", rsp1_ciphertext, '0);
            end
            if ((m_busy && cyc > m_tacc && !in_resp) || prev_rst) begin
                check_eq("core_pt", core_plaintext, m_cur_pt);
                check_eq("core_key", core_key, m_cur_key);
            end
            if (in_resp && m_kat && !m_owner)
                check_eq("kat_ct", rsp0_ciphertext, KAT_CT);
        end
        // Core model reacts to the start pulse it sees
        if (core_start === 1'b1 && !reset) begin
            c_pt  = core_plaintext;
            c_key = core_key;
            if (int'($urandom_range(99)) < p_never) c_sched = 32'h7fff_ffff;
            else c_sched = cyc + int'($urandom_range(lat_max, lat_min));
        end
        if (req0_valid && req0_ready) consumed[0] = 1'b1;
        if (req1_valid && req1_ready) consumed[1] = 1'b1;
        // Advance the reference timeline with this cycle's inputs
        if (reset) begin
            model_reset();
        end else if (!m_busy) begin
            if (exp_r0 || exp_r1) begin
                m_busy = 1; m_known = 0; m_tacc = cyc; m_owner = exp_r1;
                m_cur_pt  = exp_r1 ? req1_plaintext : req0_plaintext;
                m_cur_key = exp_r1 ? req1_key : req0_key;
                m_kat = (m_cur_pt == KAT_PT) && (m_cur_key == KAT_KEY);
            end
        end else if (!m_known) begin
            if (cyc >= m_tacc + 2 && core_done) begin
                m_known = 1; m_rcyc = cyc + 1; m_ct = core_ciphertext;
            end else if (cyc == m_tacc + 1 + int'(TIMEOUT)) begin
                m_known = 1; m_rcyc = cyc + 1; m_ct = '0; m_err = 1;
            end
        end else if (cyc >= m_rcyc && (m_owner ? rsp1_ready : rsp0_ready)) begin
            if (m_kat) n_kat++;
            m_busy = 0;
            m_last = m_owner;
        end
        prev_rst = reset;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            drive_inputs();
            @(negedge clk);
            check_and_model();
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
    endtask

    task automatic knobs(input int q0, input int q1, input int rdy, input int stray,
                         input int never, input int lmin, input int lmax);
        p_req[0] = q0; p_req[1] = q1; p_rdy = rdy; p_stray = stray;
        p_never = never; lat_min = lmin; lat_max = lmax;
    endtask

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0; n_kat = 0; c_sched = -1;
        c_pt = '0; c_key = '0; prev_rst = 0; kat_mode = 0; m_tacc = 0; m_rcyc = 0;
        model_reset();
        for (int r = 0; r < 2; r++) begin
            rv[r] = 0; rpt[r] = '0; rkey[r] = '0; rrdy[r] = 0; consumed[r] = 0;
        end
        core_done = 0; core_ciphertext = '0;
        reset = 1'b1;
        knobs(0, 0, 100, 0, 0, 1, 4);
        @(posedge clk);
        #1;
        do_reset(3);

        // Known-answer job on requester 0 only
        kat_mode = 1;
        knobs(100, 0, 100, 0, 0, 3, 6);
        step(12);
        knobs(0, 0, 100, 0, 0, 3, 6);
        step(15);
        kat_mode = 0;
        check_eq("kat_seen", DW'(n_kat != 0), DW'(1));

        // Contention straight after reset, then back-to-back alternation
        do_reset(2);
        knobs(100, 100, 100, 0, 0, 1, 4);
        step(80);

        // Response backpressure
        knobs(100, 100, 0, 0, 0, 2, 5);
        step(25);
        knobs(100, 100, 100, 0, 0, 2, 5);
        step(20);

        // Core never completes: timeout, sticky error
        knobs(100, 0, 100, 0, 100, 1, 1);
        step(150);
        knobs(0, 0, 100, 0, 0, 1, 4);
        step(10);
        check_eq("err_sticky", DW'(timeout_err), DW'(1));
        do_reset(2);

        // Stray core_done while idle
        knobs(0, 0, 100, 60, 0, 1, 4);
        step(30);

        // Reset while waiting on the core; its late done must be ignored
        knobs(100, 0, 100, 0, 0, 30, 40);
        step(10);
        knobs(0, 0, 100, 0, 0, 30, 40);
        do_reset(1);
        step(50);
        knobs(100, 100, 100, 0, 0, 1, 6);
        step(40);

        // Randomized soak with timeout-boundary latencies and rare resets
        for (int blk = 0; blk < 20; blk++) begin
            knobs(int'($urandom_range(100)), int'($urandom_range(100)),
                  int'($urandom_range(100, 20)), int'($urandom_range(30)),
                  int'($urandom_range(10)), 1, int'($urandom_range(70, 10)));
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(399) == 0) do_reset(int'($urandom_range(2, 1)));
                else step(1);
            end
        end
        knobs(0, 0, 100, 0, 0, 1, 4);
        step(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_job_arbiter.md
AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles spent in WAIT for core_done before aborting the job.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has a job pending.
REQ-005 req0_ready  output  1  arbiter accepts requester 0 job this cycle.
REQ-006 req0_plaintext  input  128  requester 0 plaintext block.
REQ-007 req0_key  input  128  requester 0 AES-128 key.
REQ-008 req1_valid, req1_ready, req1_plaintext, req1_key: same directions, widths and meanings as REQ-004..007, for requester 1.
REQ-009 rsp0_valid  output  1  ciphertext for requester 0 available.
REQ-010 rsp0_ready  input  1  requester 0 consumes response.
REQ-011 rsp0_ciphertext  output  128  result for requester 0.
REQ-012 rsp1_valid, rsp1_ready, rsp1_ciphertext: same as REQ-009..011, for requester 1.
REQ-013 core_start  output  1  single-cycle start pulse to the shared aes_core.
REQ-014 core_plaintext  output  128  plaintext driven to core.
REQ-015 core_key  output  128  key driven to core.
REQ-016 core_ciphertext  input  128  core result.
REQ-017 core_done  input  1  core completion.
REQ-018 timeout_err  output  1  sticky flag; set on any aborted job.

Function
REQ-019 FSM states SHALL be IDLE, START, WAIT, RESP.
REQ-020 IDLE: grant SHALL go round-robin; with both valid, the requester not served last wins; with one valid, that requester wins.
REQ-021 reqN_ready SHALL be asserted combinationally only in IDLE and only for the granted requester; the other ready stays 0.
REQ-022 On reqN_valid && reqN_ready, plaintext and key SHALL be registered, the owner ID stored, and the FSM SHALL move to START.
REQ-023 START: core_start=1 for exactly one cycle, then WAIT; core_plaintext/core_key SHALL hold the registered job from START through the end of WAIT.
REQ-024 WAIT: a 16-bit cycle counter SHALL clear on entry and increment each cycle.
REQ-025 In WAIT, core_done=1 SHALL capture core_ciphertext into the result register and move to RESP.
REQ-026 If the counter reaches TIMEOUT without core_done, the result register SHALL load all-zeros, timeout_err SHALL set, and the FSM SHALL move to RESP.
REQ-027 core_done in IDLE, START or RESP SHALL be ignored.
REQ-028 A simultaneous core_done and timeout in the same cycle SHALL be treated as done (no error).
REQ-029 RESP: rspN_valid of the owner only SHALL be 1 and rspN_ciphertext SHALL hold stable until rspN_ready.
REQ-030 On rspN_valid && rspN_ready, the last-served pointer SHALL update to the owner and the FSM SHALL return to IDLE; no new job is accepted in that same cycle.
REQ-031 Latency SHALL be: accept at cycle T, core_start at T+1, rsp_valid the cycle after core_done is sampled.
REQ-032 rspN_ciphertext for the non-owner SHALL be 0; exactly one job SHALL be in flight.
REQ-033 timeout_err SHALL clear only on reset.

Reset
REQ-034 While reset=1, FSM=IDLE, all ready/valid/core_start=0, core_plaintext/core_key/ciphertext outputs=0, timeout_err=0, counter=0, and the last-served pointer=1 so requester 0 wins first.
REQ-035 Reset asserted mid-job (START/WAIT/RESP) SHALL abandon the job with no response issued; the shared core is not reset by this block.

Verification
REQ-036 Single job: req0 pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> one core_start pulse, rsp0_ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a, rsp1_valid stays 0.
REQ-037 Contention: req0 and req1 valid together after reset -> req0 served first, then req1; repeated back-to-back -> strict alternation 0,1,0,1.
REQ-038 Backpressure: hold rsp0_ready=0 for 10 cycles -> rsp0_valid and data stable, req1_ready=0 throughout, job accepted the cycle after release.
REQ-039 Timeout: core model never asserts done, TIMEOUT=64 -> rsp valid with 0 ciphertext 64 cycles after WAIT entry, timeout_err=1 until reset.
REQ-040 Stray done: core_done pulsed in IDLE -> no response, no state change.
REQ-041 Reset in WAIT -> next cycle all outputs at reset values; a subsequent core_done is ignored; next job proceeds normally.
